// File: rtl/reg_pipeline_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_pipeline_pkg : shared constants, stage control encoding, count width
// Rev 1.0
// ---------------------------------------------------------------------------
package reg_pipeline_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    STAGE_HOLD  = 2'd0,
    STAGE_LOAD  = 2'd1,
    STAGE_CLEAR = 2'd2
  } stage_op_e;

  // Bits needed to represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_stage : one pipeline slot (data + valid) with load/hold/clear control
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_stage
  import reg_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  stage_op_e        op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Clearing drops only the valid bit; data is left as a don't-care.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    case (op_i)
      STAGE_LOAD: begin
        valid_d = 1'b1;
        data_d  = data_i;
      end
      STAGE_CLEAR: begin
        valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/reg_pipeline.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_pipeline : elastic register pipeline, bubble-collapsing, with flush
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_pipeline
  import reg_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] advance;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] valid_nxt;
  stage_op_e        stage_op [DEPTH];
  logic             in_xfer;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Advance chain resolves from the output side back toward the input.
  always_comb begin
    advance            = '0;
    advance[DEPTH-1]   = valid[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      advance[i] = valid[i] & (~valid[i+1] | advance[i+1]);
    end
  end

  assign in_ready = ~Reset & ~flush & (~valid[0] | advance[0]);
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    load    = '0;
    load[0] = in_xfer;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = advance[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_op[i]  = STAGE_HOLD;
      valid_nxt[i] = valid[i];
      if (flush) begin
        stage_op[i]  = STAGE_CLEAR;
        valid_nxt[i] = 1'b0;
      end else if (load[i]) begin
        stage_op[i]  = STAGE_LOAD;
        valid_nxt[i] = 1'b1;
      end else if (advance[i]) begin
        stage_op[i]  = STAGE_CLEAR;
        valid_nxt[i] = 1'b0;
      end
    end
  end

  // Count is the popcount of next-state valids, so it tracks the stages exactly.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_nxt[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] stage_in;

    if (g == 0) begin : g_head
      assign stage_in = in_data;
    end else begin : g_body
      assign stage_in = stage_data[g-1];
    end

    reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .CLK     (CLK),
      .Reset   (Reset),
      .op_i    (stage_op[g]),
      .data_i  (stage_in),
      .valid_o (valid[g]),
      .data_o  (stage_data[g])
    );
  end

  assign out_valid = valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];
  assign count     = count_q;

endmodule
`default_nettype wire
